// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: initialises a 32-entry register bank, then round-robin arbitrates two write requesters onto it
module regbank_write_arbiter #(
   parameter int N = 64,
   parameter logic [N-1:0] INIT_VALUE = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         a_valid,
   input  logic [4:0]   a_reg,
   input  logic [N-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [4:0]   b_reg,
   input  logic [N-1:0] b_data,
   output logic         b_ready,
   output logic         rf_we,
   output logic [4:0]   rf_waddr,
   output logic [N-1:0] rf_wdata,
   output logic         init_done
);
   typedef enum logic {INIT, RUN} state_t;
   state_t       r_state;
   logic [4:0]   r_idx;
   logic         r_prio;
   logic         r_we;
   logic [4:0]   r_waddr;
   logic [N-1:0] r_wdata;
   logic         r_init_done;
   logic         w_run;
   logic         w_a_grant;
   logic         w_b_grant;
   assign w_run = r_state == RUN;
   assign w_a_grant = w_run && a_valid && (!b_valid || !r_prio);
   assign w_b_grant = w_run && b_valid && (!a_valid || r_prio);
   assign a_ready = w_a_grant;
   assign b_ready = w_b_grant;
   assign rf_we = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   assign init_done = r_init_done;
   // sequencer: sweep every register with INIT_VALUE, then forward one granted write per cycle, x0 writes suppressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INIT;
         r_idx <= '0;
         r_prio <= 1'b0;
         r_we <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_init_done <= 1'b0;
      end else if (!w_run) begin
         r_we <= 1'b1;
         r_waddr <= r_idx;
         r_wdata <= INIT_VALUE;
         r_idx <= r_idx + 5'd1;
         if (r_idx == 5'd31) begin
            r_state <= RUN;
            r_init_done <= 1'b1;
         end
      end else if (w_a_grant) begin
         r_we <= a_reg != 5'd0;
         r_waddr <= a_reg;
         r_wdata <= a_data;
         r_prio <= 1'b1;
      end else if (w_b_grant) begin
         r_we <= b_reg != 5'd0;
         r_waddr <= b_reg;
         r_wdata <= b_data;
         r_prio <= 1'b0;
      end else begin
         r_we <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: randomized scoreboard bench against a behavioural arbiter/bank model
module tb_regbank_write_arbiter;
   localparam int N = 64;
   localparam logic [N-1:0] INIT_V = 64'hDEAD_BEEF_0BAD_F00D;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         a_valid = 1'b0;
   logic [4:0]   a_reg = '0;
   logic [N-1:0] a_data = '0;
   logic         a_ready;
   logic         b_valid = 1'b0;
   logic [4:0]   b_reg = '0;
   logic [N-1:0] b_data = '0;
   logic         b_ready;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [N-1:0] rf_wdata;
   logic         init_done;
   typedef struct packed {
      logic         we;
      logic [4:0]   addr;
      logic [N-1:0] data;
      logic         done;
   } exp_t;
   exp_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int m_init;
   logic m_prio;
   logic [4:0] m_addr;
   logic [N-1:0] m_data;
   regbank_write_arbiter #(.N(N), .INIT_VALUE(INIT_V)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      exp_q.delete();
      m_init = 0;
      m_prio = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask
   // one cycle: drive inputs, check readiness, and queue what the bank must show after the next edge
   task automatic step(input logic av, input logic [4:0] ar, input logic [N-1:0] ad,
                       input logic bv, input logic [4:0] br, input logic [N-1:0] bd);
      exp_t e;
      logic ga, gb;
      @(negedge clk);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      #1;
      if (m_init < 32) begin
         chk("a_ready_init", a_ready, 0);
         chk("b_ready_init", b_ready, 0);
         e = '{1'b1, 5'(m_init), INIT_V, m_init == 31};
         m_init++;
      end else begin
         ga = av && (!bv || m_prio == 1'b0);
         gb = bv && !ga;
         chk("a_ready", a_ready, ga);
         chk("b_ready", b_ready, gb);
         e.we = 1'b0;
         if (ga || gb) begin
            m_addr = ga ? ar : br;
            m_data = ga ? ad : bd;
            e.we = m_addr != 0;
            m_prio = ga;
         end
         e.addr = m_addr;
         e.data = m_data;
         e.done = 1'b1;
      end
      exp_q.push_back(e);
   endtask
   task automatic rand_step();
      logic [4:0] ar, br;
      ar = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      br = ($urandom_range(0, 2) == 0) ? ar : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), ar, {$urandom, $urandom},
           1'($urandom_range(0, 1)), br, {$urandom, $urandom});
   endtask
   // monitor: after every edge pop the predicted bank state and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", rf_we, e.we);
            chk("rf_waddr", rf_waddr, e.addr);
            chk("rf_wdata", rf_wdata, e.data);
            chk("init_done", init_done, e.done);
         end
      end
   end
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      #1 rst_n = 1'b1;
      repeat (32) rand_step();
      for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 64'hA0 + 64'(i), 1'b1, 5'd7, 64'hB0 + 64'(i));
      step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0);
      step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      step(1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hFF);
      step(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'h1010);
      repeat (5) step(1'b0, 5'd1, 64'h1, 1'b0, 5'd2, 64'h2);
      step(1'b0, 5'd0, '0, 1'b1, 5'd12, 64'hC0FFEE);
      step(1'b1, 5'd4, 64'h44, 1'b1, 5'd4, 64'h55);
      step(1'b1, 5'd4, 64'h44, 1'b1, 5'd4, 64'h55);
      repeat (300) rand_step();
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_rf_we", rf_we, 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (11) rand_step();
      @(posedge clk);
      #2;
      chk("pre_rst_waddr", rf_waddr, 10);
      a_valid = 1'b1; b_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rf_we", rf_we, 0);
      chk("async_rst_rf_waddr", rf_waddr, 0);
      chk("async_rst_rf_wdata", rf_wdata, 0);
      chk("async_rst_init_done", init_done, 0);
      chk("async_rst_a_ready", a_ready, 0);
      chk("async_rst_b_ready", b_ready, 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (32) rand_step();
      repeat (80) rand_step();
      @(posedge clk);
      #3;
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 64: register data width in bits.
REQ-002 SHALL have parameter INIT_VALUE, default 0: value written to every register during initialization.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port a_valid  input  1  requester A has a write pending.
REQ-006 SHALL have port a_reg  input  5  requester A destination register index.
REQ-007 SHALL have port a_data  input  N  requester A write data.
REQ-008 SHALL have port a_ready  output  1  requester A write accepted this cycle.
REQ-009 SHALL have ports b_valid, b_reg, b_data and b_ready, with the same directions, widths and meanings as the A ports, for requester B.
REQ-010 SHALL have port rf_we  output  1  register-bank write enable.
REQ-011 SHALL have port rf_waddr  output  5  register-bank write address.
REQ-012 SHALL have port rf_wdata  output  N  register-bank write data.
REQ-013 SHALL have port init_done  output  1  high once register-bank initialization is complete.

Function
REQ-014 SHALL implement a two-state FSM: INIT, then RUN; RUN has no exit except reset.
REQ-015 SHALL, in INIT, at each posedge drive rf_we<=1, rf_waddr<=idx, rf_wdata<=INIT_VALUE, then increment the 5-bit counter idx (idx starts at 0).
REQ-016 SHALL, at the posedge where idx==31 is written, move to RUN and set init_done<=1 on that same edge.
REQ-017 SHALL hold a_ready=b_ready=0 for the whole of INIT and ignore all valid inputs during INIT.
REQ-018 SHALL, in RUN, drive ready combinationally: only valid, sole requester valid -> that requester ready; both valid -> only the priority holder ready; neither valid -> both ready=0.
REQ-019 SHALL treat a transfer as accepted when x_valid && x_ready at a posedge; at most one transfer is accepted per cycle.
REQ-020 SHALL register each accepted transfer onto the bank on the same edge: rf_waddr<=x_reg, rf_wdata<=x_data, rf_we<=(x_reg!=0), giving one-cycle latency from handshake to the bank write.
REQ-021 SHALL accept writes to register 0 normally (ready asserted, handshake completes) but keep rf_we=0 for them, so x0 stays hardwired.
REQ-022 SHALL drive rf_we<=0 at every RUN posedge with no accepted transfer, leaving rf_waddr and rf_wdata unchanged.
REQ-023 SHALL keep a 1-bit priority pointer: 0 = A, 1 = B.
REQ-024 SHALL, after every accepted transfer, point the priority pointer at the non-granted requester; with no transfer, the pointer SHALL hold.
REQ-025 SHALL NOT merge or reorder simultaneous requests to the same register: each is granted separately, in priority order.
REQ-026 SHALL permit the first RUN handshake in the cycle where init_done first reads 1, with no idle bank cycle after the idx 31 write.
REQ-027 SHALL place no requirement that valid stays stable; a requester not granted retries by keeping valid high.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, force: state=INIT, idx=0, priority pointer=A, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, a_ready=0, b_ready=0.
REQ-029 SHALL, on reset assertion mid-INIT or mid-RUN, abandon any in-progress sequence and restart INIT at idx 0 after release.

Verification
REQ-030 SHALL verify: rst_n released -> 32 consecutive cycles with rf_we=1, rf_waddr 0..31, rf_wdata=INIT_VALUE; init_done rises with addr 31; a_ready=b_ready=0 throughout.
REQ-031 SHALL verify: RUN, a_valid=1, a_reg=5, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; the cycle after that rf_we=0.
REQ-032 SHALL verify: RUN, a_valid and b_valid held high for 4 cycles from a reset-fresh pointer -> grant order A, B, A, B, with bank addresses matching each granted request.
REQ-033 SHALL verify: RUN, b_valid=1, b_reg=0, b_data=0xFF -> b_ready=1 and rf_we stays 0; the pointer moves to A.
REQ-034 SHALL verify: rst_n pulsed low while rf_waddr=10 in INIT -> outputs zero immediately without a clock edge; after release INIT restarts at address 0.
REQ-035 SHALL verify: RUN, no valids for 5 cycles -> rf_we=0, pointer unchanged, and the following single-requester transfer is granted immediately.
